// File: rtl/l2_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : l2_types (package)
// Description : Shared widths, derived constants, state encoding and an
//               address-alignment helper for the L2 memory-side line adaptor.
// Revision    : 1.0 - initial release
// ============================================================================
package l2_types;

    localparam int S_LINE      = 256;
    localparam int S_BURST     = 64;
    localparam int S_ADDR      = 32;
    localparam int BEATS       = S_LINE / S_BURST;
    localparam int OFFSET_BITS = $clog2(S_LINE / 8);
    localparam int CNT_W       = $clog2(BEATS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } adaptor_state_t;

    // Clears the byte-within-line offset so memory always sees a line-aligned address.
    function automatic logic [S_ADDR-1:0] line_align(input logic [S_ADDR-1:0] addr);
        return addr & ~{{(S_ADDR - OFFSET_BITS){1'b0}}, {OFFSET_BITS{1'b1}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/l2_cacheline_adaptor_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : l2_line_buffer
// Description : One cache line of storage organised as beats. Supports a
//               whole-line load, a single beat write at an index, an indexed
//               combinational beat read and a whole-line view.
// Revision    : 1.0 - initial release
// ============================================================================
module l2_line_buffer #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64,
    parameter int IDX_W  = $clog2(LINE_W / BEAT_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line_load,
    input  logic [LINE_W-1:0] line_in,
    input  logic              beat_load,
    input  logic [IDX_W-1:0]  index,
    input  logic [BEAT_W-1:0] beat_in,
    output logic [BEAT_W-1:0] beat_out,
    output logic [LINE_W-1:0] line_out
);

    localparam int NB = LINE_W / BEAT_W;

    logic [BEAT_W-1:0] r_beat [NB];

    generate
        for (genvar g = 0; g < NB; g++) begin : g_beat
            // Each slot takes the whole-line load first, otherwise its own indexed beat write.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_beat[g] <= '0;
                end else if (line_load) begin
                    r_beat[g] <= line_in[g*BEAT_W +: BEAT_W];
                end else if (beat_load && (index == IDX_W'(g))) begin
                    r_beat[g] <= beat_in;
                end
            end

            assign line_out[g*BEAT_W +: BEAT_W] = r_beat[g];
        end
    endgenerate

    // Indexed read port: selects the slot addressed by the current beat count.
    always_comb begin
        beat_out = '0;
        for (int b = 0; b < NB; b++) begin
            if (index == IDX_W'(b)) begin
                beat_out = r_beat[b];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/l2_cacheline_adaptor.sv
`default_nettype none
// ============================================================================
// Module      : l2_cacheline_adaptor
// Description : Converts a whole-line read/write from the L2 controller into a
//               4-beat 64-bit burst toward physical memory, reassembling read
//               beats into a 256-bit line. Holds the FSM, beat counter and
//               address latch; line storage lives in two l2_line_buffer copies.
// Revision    : 1.0 - initial release
// ============================================================================
module l2_cacheline_adaptor
    import l2_types::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [S_LINE-1:0] line_i,
    output logic [S_LINE-1:0] line_o,
    input  logic [S_ADDR-1:0] address_i,
    input  logic              read_i,
    input  logic              write_i,
    output logic              resp_o,
    input  logic [S_BURST-1:0] burst_i,
    output logic [S_BURST-1:0] burst_o,
    output logic [S_ADDR-1:0] address_o,
    output logic              read_o,
    output logic              write_o,
    input  logic              resp_i
);

    localparam logic [CNT_W-1:0] C_LAST_BEAT = CNT_W'(BEATS - 1);

    adaptor_state_t     r_state;
    adaptor_state_t     w_state_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_nxt;
    logic [S_ADDR-1:0]  r_addr;

    logic               w_accept_wr;
    logic               w_accept_rd;
    logic               w_rd_beat;
    logic [S_BURST-1:0] w_wr_beat;
    logic [S_BURST-1:0] w_rd_beat_unused;
    logic [S_LINE-1:0]  w_wr_line_unused;

    // State and beat counter register; reset aborts any burst in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Next-state and beat sequencing; write wins when both requests arrive together.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_accept_wr = 1'b0;
        w_accept_rd = 1'b0;
        w_rd_beat   = 1'b0;
        case (r_state)
            IDLE: begin
                if (write_i) begin
                    w_accept_wr = 1'b1;
                    w_count_nxt = '0;
                    w_state_nxt = WRITE;
                end else if (read_i) begin
                    w_accept_rd = 1'b1;
                    w_count_nxt = '0;
                    w_state_nxt = READ;
                end
            end
            READ: begin
                if (resp_i) begin
                    w_rd_beat   = 1'b1;
                    w_count_nxt = r_count + 1'b1;
                    if (r_count == C_LAST_BEAT) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            WRITE: begin
                if (resp_i) begin
                    w_count_nxt = r_count + 1'b1;
                    if (r_count == C_LAST_BEAT) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Address latch, captured line-aligned when a request is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
        end else if (w_accept_wr || w_accept_rd) begin
            r_addr <= line_align(address_i);
        end
    end

    // Read assembly: beats from memory land in the slot named by the counter.
    l2_line_buffer #(
        .LINE_W (S_LINE),
        .BEAT_W (S_BURST)
    ) u_rd_buf (
        .clk       (clk),
        .rst       (rst),
        .line_load (1'b0),
        .line_in   ({S_LINE{1'b0}}),
        .beat_load (w_rd_beat),
        .index     (r_count),
        .beat_in   (burst_i),
        .beat_out  (w_rd_beat_unused),
        .line_out  (line_o)
    );

    // Write disassembly: the whole line is captured at acceptance, then read out per beat.
    l2_line_buffer #(
        .LINE_W (S_LINE),
        .BEAT_W (S_BURST)
    ) u_wr_buf (
        .clk       (clk),
        .rst       (rst),
        .line_load (w_accept_wr),
        .line_in   (line_i),
        .beat_load (1'b0),
        .index     (r_count),
        .beat_in   ({S_BURST{1'b0}}),
        .beat_out  (w_wr_beat),
        .line_out  (w_wr_line_unused)
    );

    // Handshake outputs decode from state only, so no input reaches them combinationally.
    assign read_o    = (r_state == READ);
    assign write_o   = (r_state == WRITE);
    assign resp_o    = (r_state == DONE);
    assign burst_o   = (r_state == WRITE) ? w_wr_beat : '0;
    assign address_o = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_l2_cacheline_adaptor.sv
`default_nettype none
// ============================================================================
// Module      : tb_l2_cacheline_adaptor
// Description : Self-checking bench for l2_cacheline_adaptor. Directed cases
//               followed by randomized transactions against a line-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_cacheline_adaptor;

    localparam int LW = 256;
    localparam int BW = 64;
    localparam int NB = LW / BW;

    logic          clk;
    logic          rst;
    logic [LW-1:0] line_i;
    logic [LW-1:0] line_o;
    logic [31:0]   address_i;
    logic          read_i;
    logic          write_i;
    logic          resp_o;
    logic [BW-1:0] burst_i;
    logic [BW-1:0] burst_o;
    logic [31:0]   address_o;
    logic          read_o;
    logic          write_o;
    logic          resp_i;

    int            n_vec;
    int            n_err;
    logic [LW-1:0] m_line;

    l2_cacheline_adaptor u_dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Idle cycles with stray memory strobes; nothing may move.
    task automatic idle(input int n);
        read_i  = 1'b0;
        write_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            resp_i  = 1'($urandom_range(0, 1));
            burst_i = {$urandom, $urandom};
            tick();
            check("idle_hs", {read_o, write_o, resp_o}, 3'b000);
            check("idle_line", line_o, m_line);
        end
        resp_i = 1'b0;
    endtask

    // One line transaction. rdata supplies read beats; pat gives the resp_i per busy
    // cycle when use_pat is set (1 after bit 15), else random stalls capped at 3 in a row.
    // keep_rd leaves read_i high after completion for a back-to-back read.
    task automatic do_txn(input bit wr, input bit rd, input logic [31:0] addr,
                          input logic [LW-1:0] line, input logic [LW-1:0] rdata,
                          input logic [15:0] pat, input bit use_pat, input bit keep_rd);
        bit            is_wr;
        bit            r;
        int            k;
        int            cyc;
        int            stalls;
        logic [31:0]   exp_addr;
        is_wr    = wr;
        k        = 0;
        cyc      = 0;
        stalls   = 0;
        exp_addr = {addr[31:5], 5'b0};
        write_i   = wr;
        read_i    = rd;
        address_i = addr;
        line_i    = line;
        resp_i    = 1'b0;
        tick();
        line_i    = rand_line();
        address_i = $urandom;
        check("address_o", address_o, exp_addr);
        while (k < NB) begin
            check("busy_rw", {read_o, write_o}, is_wr ? 2'b01 : 2'b10);
            check("busy_resp_o", resp_o, 1'b0);
            if (is_wr) check("burst_o", burst_o, line[k*BW +: BW]);
            if (use_pat) r = (cyc < 16) ? pat[cyc] : 1'b1;
            else         r = (stalls >= 3) ? 1'b1 : ($urandom_range(0, 2) != 0);
            resp_i  = r;
            burst_i = rdata[k*BW +: BW];
            if (r && !is_wr) m_line[k*BW +: BW] = burst_i;
            tick();
            if (r) begin
                k++;
                stalls = 0;
            end else begin
                stalls++;
            end
            cyc++;
        end
        resp_i  = 1'($urandom_range(0, 1));
        burst_i = {$urandom, $urandom};
        check("done_resp_o", resp_o, 1'b1);
        check("done_rw", {read_o, write_o}, 2'b00);
        check("done_line_o", line_o, m_line);
        write_i = 1'b0;
        if (!keep_rd) read_i = 1'b0;
        tick();
        resp_i = 1'b0;
        check("post_resp_o", resp_o, 1'b0);
        check("post_rw", {read_o, write_o}, 2'b00);
    endtask

    initial begin
        logic [LW-1:0] dline;
        n_vec     = 0;
        n_err     = 0;
        m_line    = '0;
        rst       = 1'b0;
        line_i    = '0;
        address_i = '0;
        read_i    = 1'b0;
        write_i   = 1'b0;
        burst_i   = '0;
        resp_i    = 1'b0;

        // Asynchronous reset asserted mid-cycle.
        #2 rst = 1'b1;
        #1;
        check("rst_hs", {read_o, write_o, resp_o}, 3'b000);
        check("rst_burst_o", burst_o, '0);
        check("rst_address_o", address_o, '0);
        check("rst_line_o", line_o, '0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("rel_hs", {read_o, write_o, resp_o}, 3'b000);

        // Directed read, no stalls.
        dline = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        do_txn(1'b0, 1'b1, 32'h1234_5678, '0, dline, 16'hFFFF, 1'b1, 1'b0);
        check("dir_read_line", line_o, dline);

        // Directed write with stall pattern 1,0,0,1,1,0,1.
        dline = {{16{4'hA}}, {16{4'hB}}, {16{4'hC}}, {16{4'hD}}};
        do_txn(1'b1, 1'b0, 32'hCAFE_F00D, dline, rand_line(), 16'h0059, 1'b1, 1'b0);

        // Both requests: write only, then read_i held over for a back-to-back read.
        do_txn(1'b1, 1'b1, 32'h0000_1040, rand_line(), rand_line(), 16'h0, 1'b0, 1'b1);
        do_txn(1'b0, 1'b1, 32'h0000_2080, '0, rand_line(), 16'h0, 1'b0, 1'b0);

        // Reset during a read after two beats.
        read_i    = 1'b1;
        address_i = 32'hDEAD_BEEF;
        tick();
        for (int i = 0; i < 2; i++) begin
            resp_i  = 1'b1;
            burst_i = {$urandom, $urandom};
            tick();
        end
        resp_i = 1'b0;
        check("pre_rst_read_o", read_o, 1'b1);
        #2 rst = 1'b1;
        #1;
        m_line = '0;
        check("mid_rst_hs", {read_o, write_o, resp_o}, 3'b000);
        check("mid_rst_line_o", line_o, m_line);
        check("mid_rst_address_o", address_o, '0);
        read_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("after_rst_hs", {read_o, write_o, resp_o}, 3'b000);
        do_txn(1'b0, 1'b1, 32'h0BAD_F00D, '0, rand_line(), 16'h0, 1'b0, 1'b0);

        // Stray strobes while idle must not shift the next read's beat slots.
        idle(5);
        do_txn(1'b0, 1'b1, 32'h7777_0000, '0, rand_line(), 16'hFFFF, 1'b1, 1'b0);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            bit wr;
            bit rd;
            wr = 1'($urandom_range(0, 1));
            rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            do_txn(wr, rd, $urandom, rand_line(), rand_line(), 16'h0, 1'b0, 1'b0);
            idle($urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/l2_cacheline_adaptor.md
# l2_cacheline_adaptor

Memory-side bridge for the L2 cache: turns one whole-line read or write request from the L2 controller into a 4-beat, 64-bit burst transaction on physical memory, and reassembles returning beats into a 256-bit line. It sits between the L2 controller (line side) and the memory arbiter/physical memory (burst side). It is the initiator toward memory for the line data stored in the L2 data and tag arrays.

## Interface
- s_line, 256, line width in bits
- s_burst, 64, beat width in bits; beat count = s_line/s_burst (4), must be a power of two ≥2
- s_addr, 32, address width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- line_i  in  s_line  write data from L2, sampled at write acceptance
- line_o  out  s_line  read data to L2, valid from resp_o until next accepted request
- address_i  in  s_addr  line address from L2
- read_i  in  1  line read request, held by L2 until resp_o
- write_i  in  1  line write request, held by L2 until resp_o
- resp_o  out  1  one-cycle completion pulse to L2
- burst_i  in  s_burst  read beat from memory
- burst_o  out  s_burst  write beat to memory
- address_o  out  s_addr  latched address, low log2(s_line/8) bits forced to 0
- read_o  out  1  burst read request to memory
- write_o  out  1  burst write request to memory
- resp_i  in  1  memory beat strobe: one beat transferred per cycle it is high

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: if write_i, latch address_i and line_i, clear beat count, go to WRITE; else if read_i, latch address_i, clear count, go to READ. Both high: write wins.
- READ: read_o=1. Each cycle resp_i=1: store burst_i into line slot [count] (beat 0 = bits 63:0), count+1. On the resp_i of the last beat go to DONE.
- WRITE: write_o=1, burst_o = latched line slot [count]. Each resp_i=1 advances count; on last beat go to DONE.
- DONE: resp_o=1 for exactly one cycle, then IDLE. read_o/write_o are 0.
- read_i/write_i are ignored outside IDLE. A request still high in IDLE the cycle after resp_o starts a new transaction. L2 must drop it at resp_o.
- resp_i outside READ/WRITE is ignored, and the count does not change.
- Beat count is log2(beats) bits wide and wraps to 0 after the last beat.
- The line_o buffer is not cleared by new write transactions; it is overwritten only by read beats.

## Timing
- Reset (async): state IDLE, count 0, read_o=write_o=resp_o=0, burst_o=0, address_o=0, line_o=0.
- Reset during READ/WRITE aborts the burst. read_o/write_o drop immediately; no resp_o.
- read_o, write_o and resp_o decode from state only: no combinational path from any input.
- Request sampled at edge 0 → read_o/write_o high from cycle 1. With resp_i held high, beats land in cycles 1–4, DONE/resp_o in cycle 5, and IDLE in cycle 6. Minimum turnaround is 6 cycles.
- Stalls: resp_i low holds count and burst_o. read_o/write_o stay high.
- line_o reflects all 4 beats by the resp_o cycle.

## Structure
- Package l2_types: S_LINE, S_BURST, S_ADDR, BEATS, OFFSET_BITS constants; adaptor_state_t enum {IDLE, READ, WRITE, DONE}.
- Sub-module l2_line_buffer: s_line register with async reset. It has a beat-indexed write port (load, index, beat_in), a beat-indexed combinational read port (index → beat_out), and full-line load/out. It is used for both the read assembly and the write disassembly.
- The top level holds the FSM, the beat counter and the address latch.

## Test plan
- Reset: assert rst mid-cycle → all outputs 0 asynchronously; release → IDLE, no spurious read_o.
- Read, no stall: address_i=0x1234_5678 with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive resp_i → address_o=0x1234_5660, line_o={44..,33..,22..,11..}, resp_o in cycle 5 only.
- Write with stalls: line_i=256'hA..A_B..B_C..C_D..D, resp_i pattern 1,0,0,1,1,0,1 → burst_o sequence D,C,B,A, each held across stalls, write_o high until last beat, then a single resp_o.
- Simultaneous read_i=write_i=1 → write transaction only; read_o never asserted. After resp_o, read_i still high → new read starts next cycle.
- Reset during READ after 2 beats → read_o falls immediately, no resp_o. A subsequent read returns fresh data in all 4 slots.
- Stray resp_i in IDLE/DONE → count unchanged; the next read lands beat 0 in bits 63:0.
